risk_mem_responder: RTL and testbench

//   Memory-side responder for the CPU's memory requests: 32 x 8-bit storage that

---
 rtl/risk_mem_responder.sv | 133 +++++++++++++
 tb/tb_risk_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risk_mem_responder.sv
// rtl/risk_mem_responder.sv - 32x8 memory responder with req/ack handshake, wait states and preload port
module risk_mem_responder #(
    parameter int AW   = 5,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          R,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          busy,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_err
);

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;
    logic            w_ld_write;
    logic            w_acc_write;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_ack;
    logic            r_ld_err;
    logic [DW-1:0]   r_mem [DEPTH];

    // State register; reset drops any in-flight access
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the preload port has priority over a request in IDLE
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && !ld_en) begin
                    w_accept     = 1'b1;
                    w_next_state = (WAIT_CNT == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                // r_cnt <= 1 also guards against a stuck counter
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign w_ld_write  = (r_state == S_IDLE) && ld_en;
    assign w_acc_write = (r_state == S_ACK) && r_we;

    // Request latch and wait-state counter
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= WAIT_CNT;
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Completion pulse, read data capture and rejected-preload pulse
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_ld_err <= 1'b0;
        end else begin
            r_ack    <= (r_state == S_ACK);
            r_ld_err <= ld_en && busy;
            if ((r_state == S_ACK) && !r_we) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // Storage array; preload and access writes never coincide (IDLE vs ACK)
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_ld_write) begin
            r_mem[ld_addr] <= ld_data;
        end else if (w_acc_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rdata  = r_rdata;
    assign ack    = r_ack;
    assign ld_err = r_ld_err;

endmodule

// File: tb/tb_risk_mem_responder.sv
// tb/tb_risk_mem_responder.sv - self-checking bench for risk_mem_responder with WAIT=1,0,3 instances
module tb_risk_mem_responder;

    logic       clk;
    logic       R;
    logic       req     [3];
    logic       we      [3];
    logic [4:0] addr    [3];
    logic [7:0] wdata   [3];
    logic [7:0] rdata   [3];
    logic       ack     [3];
    logic       busy    [3];
    logic       ld_en   [3];
    logic [4:0] ld_addr [3];
    logic [7:0] ld_data [3];
    logic       ld_err  [3];

    int total;
    int bad;
    int cyc;
    bit chk_en;

    // Behavioural model: one outstanding transaction per instance that completes
    // WAIT+1 edges after acceptance
    logic [7:0] m_mem   [3][32];
    logic [7:0] m_rdata [3];
    logic       m_ack   [3];
    logic       m_lderr [3];
    logic       m_infl  [3];
    int         m_left  [3];
    logic       m_we    [3];
    logic [4:0] m_a     [3];
    logic [7:0] m_d     [3];

    function automatic int wv(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    risk_mem_responder #(.AW(5), .DW(8), .WAIT(1)) u0 (
        .clk(clk), .R(R), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .ld_en(ld_en[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_err(ld_err[0]));

    risk_mem_responder #(.AW(5), .DW(8), .WAIT(0)) u1 (
        .clk(clk), .R(R), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .ld_en(ld_en[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_err(ld_err[1]));

    risk_mem_responder #(.AW(5), .DW(8), .WAIT(3)) u2 (
        .clk(clk), .R(R), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .ld_en(ld_en[2]),
        .ld_addr(ld_addr[2]), .ld_data(ld_data[2]), .ld_err(ld_err[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge R) begin
        for (int i = 0; i < 3; i++) begin
            if (!R) begin
                for (int j = 0; j < 32; j++) m_mem[i][j] = 8'h00;
                m_rdata[i] = 8'h00;
                m_ack[i]   = 1'b0;
                m_lderr[i] = 1'b0;
                m_infl[i]  = 1'b0;
                m_left[i]  = 0;
            end else begin
                m_ack[i]   = 1'b0;
                m_lderr[i] = 1'b0;
                if (m_infl[i]) begin
                    if (ld_en[i]) m_lderr[i] = 1'b1;
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        if (m_we[i]) m_mem[i][m_a[i]] = m_d[i];
                        else         m_rdata[i] = m_mem[i][m_a[i]];
                        m_ack[i]  = 1'b1;
                        m_infl[i] = 1'b0;
                    end
                end else if (ld_en[i]) begin
                    m_mem[i][ld_addr[i]] = ld_data[i];
                end else if (req[i]) begin
                    m_infl[i] = 1'b1;
                    m_left[i] = wv(i) + 1;
                    m_we[i]   = we[i];
                    m_a[i]    = addr[i];
                    m_d[i]    = wdata[i];
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d_ack", i),    {31'd0, ack[i]},    {31'd0, m_ack[i]});
                check($sformatf("u%0d_busy", i),   {31'd0, busy[i]},   {31'd0, m_infl[i]});
                check($sformatf("u%0d_ld_err", i), {31'd0, ld_err[i]}, {31'd0, m_lderr[i]});
                check($sformatf("u%0d_rdata", i),  {24'd0, rdata[i]},  {24'd0, m_rdata[i]});
            end
        end
    end

    task automatic preload(input int i, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en[i] = 1'b1; ld_addr[i] = a; ld_data[i] = d;
        @(negedge clk);
        ld_en[i] = 1'b0;
    endtask

    // Wait (bounded) for ack on instance i; returns edges waited
    task automatic wait_ack(input int i, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #3;
            n++;
            if (ack[i]) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // Single access from IDLE; lat = edges between acceptance and ack
    task automatic access(input int i, input logic w, input logic [4:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output logic busy_acc);
        int n;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        #3;
        busy_acc = busy[i];
        if (ack[i]) n = 0;
        else wait_ack(i, n);
        lat = n;
        rd = rdata[i];
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    logic [7:0] rd;
    int         lat;
    logic       bacc;
    int         t_ack [3];
    int         n;
    logic [7:0] exp6 [3];

    initial begin
        total = 0; bad = 0; cyc = 0; chk_en = 1'b0;
        R = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            ld_en[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
        end
        #1 R = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        R = 1'b1;

        // 1. reset state and all-zero memory
        @(posedge clk); #3;
        check("rst_rdata", {24'd0, rdata[0]}, 32'h0);
        check("rst_ack", {31'd0, ack[0]}, 32'h0);
        check("rst_busy", {31'd0, busy[0]}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            access(0, 1'b0, 5'(a), 8'h00, rd, lat, bacc);
            check($sformatf("rst_mem_%0d", a), {24'd0, rd}, 32'h0);
        end

        // 2. preload then read, WAIT=1
        preload(0, 5'h03, 8'hA7);
        access(0, 1'b0, 5'h03, 8'h00, rd, lat, bacc);
        check("t2_busy_at_accept", {31'd0, bacc}, 32'h1);
        check("t2_latency", lat, 2);
        check("t2_rdata", {24'd0, rd}, 32'hA7);

        // 3. write then read back, WAIT=0
        access(1, 1'b1, 5'h1F, 8'h5C, rd, lat, bacc);
        check("t3_wr_latency", lat, 1);
        check("t3_wr_rdata_held", {24'd0, rd}, 32'h00);
        access(1, 1'b0, 5'h1F, 8'h00, rd, lat, bacc);
        check("t3_rd_rdata", {24'd0, rd}, 32'h5C);

        // 4a. preload and request together in IDLE: loader wins, request waits
        @(negedge clk);
        ld_en[0] = 1'b1; ld_addr[0] = 5'h0A; ld_data[0] = 8'h3C;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'h0A;
        @(posedge clk); #3;
        check("t4_loader_wins", {31'd0, busy[0]}, 32'h0);
        @(negedge clk);
        ld_en[0] = 1'b0;
        @(posedge clk); #3;
        check("t4_req_accepted", {31'd0, busy[0]}, 32'h1);
        wait_ack(0, n);
        check("t4_preload_visible", {24'd0, rdata[0]}, 32'h3C);
        @(negedge clk);
        req[0] = 1'b0;

        // 4b. preload while busy is rejected
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'h03;
        @(negedge clk);
        ld_en[0] = 1'b1; ld_addr[0] = 5'h03; ld_data[0] = 8'h11;
        @(posedge clk); #3;
        check("t4_ld_err", {31'd0, ld_err[0]}, 32'h1);
        @(negedge clk);
        ld_en[0] = 1'b0;
        @(posedge clk); #3;
        check("t4_ld_err_one_cycle", {31'd0, ld_err[0]}, 32'h0);
        check("t4_ack", {31'd0, ack[0]}, 32'h1);
        check("t4_mem_unchanged", {24'd0, rdata[0]}, 32'hA7);
        @(negedge clk);
        req[0] = 1'b0;

        // 5. reset during wait states of a write, WAIT=3
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 5'h04; wdata[2] = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        R = 1'b0; req[2] = 1'b0;
        repeat (2) @(negedge clk);
        R = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #3;
            check($sformatf("t5_no_ack_%0d", k), {31'd0, ack[2]}, 32'h0);
        end
        access(2, 1'b0, 5'h04, 8'h00, rd, lat, bacc);
        check("t5_latency", lat, 4);
        check("t5_mem_cleared", {24'd0, rd}, 32'h00);

        // 6. back-to-back reads with req held, WAIT=1
        preload(0, 5'h00, 8'h11);
        preload(0, 5'h01, 8'h22);
        preload(0, 5'h02, 8'h33);
        exp6[0] = 8'h11; exp6[1] = 8'h22; exp6[2] = 8'h33;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'h00;
        for (int j = 0; j < 3; j++) begin
            wait_ack(0, n);
            t_ack[j] = cyc;
            check($sformatf("t6_rdata_%0d", j), {24'd0, rdata[0]}, {24'd0, exp6[j]});
            @(negedge clk);
            if (j < 2) addr[0] = 5'(j + 1);
            else       req[0] = 1'b0;
        end
        check("t6_spacing_01", t_ack[1] - t_ack[0], 3);
        check("t6_spacing_12", t_ack[2] - t_ack[1], 3);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
